// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and defaults for the shift-and-add multiplier.
// The state encoding matches the divider controller.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int N_DEF    = 10;
    localparam int CNTW_DEF = 4;

endpackage

// File: rtl/shift_add_multiplier_ctrl.sv
// Control FSM and iteration counter for the shift-and-add multiplier.
// ZERO_SKIP_EN: a zero operand sends the accepting edge straight to DONE.
module shift_add_multiplier_ctrl
    import shift_add_multiplier_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef ZERO_SKIP_EN
    input  logic opnd_zero,
`endif
    output logic ld_a,
    output logic ld_q,
    output logic clr_acc,
    output logic sh_acc,
    output logic sh_q,
    output logic busy,
    output logic done
);

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic            accept;
    logic            cnt_en;
    logic            last;
    logic            skip;

    // Datapath strobes act on the same edge as the state change, so they are decoded.
    assign accept  = (state == S_IDLE) && start;
    assign ld_a    = accept;
    assign ld_q    = accept;
    assign clr_acc = accept;
    assign sh_acc  = (state == S_CALC);
    assign sh_q    = (state == S_CALC);
    assign cnt_en  = (state == S_CALC);
    assign last    = (cnt == CNTW'(N - 1));

`ifdef ZERO_SKIP_EN
    assign skip = opnd_zero;
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (accept)
                cnt <= '0;
            else if (cnt_en)
                cnt <= cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (skip) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned radix-2 shift-and-add multiplier, product = {acc, q}.
// ZERO_SKIP_EN: zero operands finish one edge after acceptance with product 0.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   inA,
    input  logic [N-1:0]   inB,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    logic [N-1:0] reg_a;
    logic [N-1:0] acc;
    logic [N-1:0] q;
    logic [N:0]   sum;
    logic [N-1:0] q_load;
    logic         ld_a, ld_q, clr_acc, sh_acc, sh_q;

`ifdef ZERO_SKIP_EN
    logic opnd_zero;
    assign opnd_zero = ~|inA | ~|inB;
    assign q_load    = opnd_zero ? '0 : inB;
`else
    assign q_load    = inB;
`endif

    shift_add_multiplier_ctrl #(.N(N), .CNTW(CNTW)) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
`ifdef ZERO_SKIP_EN
        .opnd_zero (opnd_zero),
`endif
        .ld_a    (ld_a),
        .ld_q    (ld_q),
        .clr_acc (clr_acc),
        .sh_acc  (sh_acc),
        .sh_q    (sh_q),
        .busy    (busy),
        .done    (done)
    );

    // Carry out of the add lands in acc's MSB after the shift.
    assign sum = {1'b0, acc} + (q[0] ? {1'b0, reg_a} : {(N+1){1'b0}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a <= '0;
            acc   <= '0;
            q     <= '0;
        end else begin
            if (ld_a)
                reg_a <= inA;
            if (clr_acc)
                acc <= '0;
            else if (sh_acc)
                acc <= sum[N:1];
            if (ld_q)
                q <= q_load;
            else if (sh_q)
                q <= {sum[0], q[N-1:1]};
        end
    end

    assign product = {acc, q};

endmodule
